// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, mul/div EX occupancy with watchdog, branch flushes.
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned TO_W       = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs1_addr,
  input  logic [4:0]       if_id_rs2_addr,
  input  logic             if_id_use_rs1,
  input  logic             if_id_use_rs2,
  input  logic [4:0]       id_ex_rd_addr,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_is_muldiv,
  input  logic             md_done,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             md_start,
  output logic             md_abort,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  localparam logic [TO_W-1:0] WdLimit = TO_W'(MD_TIMEOUT);

  state_e          state_q;
  logic [TO_W-1:0] wd_q;
  logic            timeout_q;
  logic            load_use;
  logic            wd_expired;

  assign load_use = id_ex_mem_read && (id_ex_rd_addr != 5'd0) &&
                    ((if_id_use_rs1 && (id_ex_rd_addr == if_id_rs1_addr)) ||
                     (if_id_use_rs2 && (id_ex_rd_addr == if_id_rs2_addr)));

  assign wd_expired = (wd_q == WdLimit);
  assign md_timeout = timeout_q;

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;
    md_abort      = 1'b0;
    case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (id_ex_is_muldiv) begin
          md_start      = 1'b1;
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      StMdBusy: begin
        // md_done wins over an expiring watchdog: EX/MEM captures the result
        if (!md_done) begin
          if (wd_expired) begin
            md_abort      = 1'b1;
            ex_mem_bubble = 1'b1;
          end else begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (!ex_branch_taken && id_ex_is_muldiv) begin
            state_q <= StMdBusy;
            wd_q    <= TO_W'(1);
          end
        end
        StMdBusy: begin
          if (md_done) begin
            state_q <= StRun;
            wd_q    <= '0;
          end else if (wd_expired) begin
            state_q   <= StRun;
            wd_q      <= '0;
            timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters; they never wrap back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against
// a cycle-level behavioural model of the hazard rules.
module tb_hazard_stall_ctrl;

  localparam int unsigned T     = 8;
  localparam int unsigned CNT_W = 32;
`ifdef HAZ_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, mem_read, is_muldiv, md_done, branch;
  logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic md_start, md_abort, md_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  // Model state: busy with a mul/div, cycles since md_start, sticky error, event counts
  bit      m_busy;
  int      m_elapsed;
  bit      m_to;
  longint  m_stall;
  longint  m_flush;

  always #5 clk = ~clk;

  assign outs = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_bubble, ex_mem_bubble,
                 md_start, md_abort, md_timeout};

  hazard_stall_ctrl #(.MD_TIMEOUT(T), .TO_W(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1_addr(rs1), .if_id_rs2_addr(rs2),
    .if_id_use_rs1(use1), .if_id_use_rs2(use2),
    .id_ex_rd_addr(rd), .id_ex_mem_read(mem_read), .id_ex_is_muldiv(is_muldiv),
    .md_done(md_done), .ex_branch_taken(branch),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .md_start(md_start), .md_abort(md_abort), .md_timeout(md_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Expected output vector from the hazard rules, bit order as in 'outs'
  function automatic logic [8:0] model_outs();
    logic [8:0] e;
    bit lu;
    lu = mem_read && (rd != 0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
    e = '0;
    if (!m_busy) begin
      if (branch)          e = 9'b000_110_000;
      else if (is_muldiv)  e = 9'b111_001_100;
      else if (lu)         e = 9'b110_010_000;
    end else if (!md_done) begin
      if (m_elapsed == T)  e = 9'b000_001_010;
      else                 e = 9'b111_001_000;
    end
    e[0] = m_to;
    return e;
  endfunction

  // Advance the model across the coming clock edge, using the inputs currently applied
  task automatic model_step(input logic [8:0] e);
    if (e[8] && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (e[5] && m_flush < 64'hFFFF_FFFF) m_flush++;
    if (!m_busy) begin
      if (!branch && is_muldiv) begin
        m_busy    = 1'b1;
        m_elapsed = 1;
      end
    end else if (md_done) begin
      m_busy = 1'b0;
    end else if (m_elapsed == T) begin
      m_busy = 1'b0;
      m_to   = 1'b1;
    end else begin
      m_elapsed++;
    end
  endtask

  task automatic set_idle();
    rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0;
    mem_read = 0; is_muldiv = 0; md_done = 0; branch = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    set_idle();
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    m_busy = 0; m_elapsed = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic test_reset();
    logic [CNT_W-1:0] zero;
    zero = '0;
    do_reset(2);
    #1;
    checks++;
    if (outs !== 9'd0) begin
      errors++; $display("FAIL reset_outs got %b want %b", outs, 9'd0);
    end
    checks++;
    if (stall_cycles !== zero || flush_count !== zero) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
  endtask

  task automatic test_load_use();
    // {mem_read, rd, rs1, use1, rs2, use2} per cycle
    logic [17:0] tbl [6];
    logic [8:0]  e;
    tbl[0] = {1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0};
    tbl[1] = {1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0};
    tbl[2] = {1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1};
    tbl[3] = {1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1};
    tbl[4] = {1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0};
    tbl[5] = {1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_idle();
      {mem_read, rd, rs1, use1, rs2, use2} = tbl[i];
      #1;
      e = model_outs();
      checks++;
      if (outs !== e) begin
        errors++; $display("FAIL load_use[%0d] got %b want %b", i, outs, e);
      end
      model_step(e);
    end
  endtask

  task automatic test_branch_priority();
    logic [8:0] e;
    longint f0;
    f0 = m_flush;
    @(negedge clk);
    set_idle();
    branch = 1; mem_read = 1; rd = 3; rs1 = 3; use1 = 1;
    #1;
    e = model_outs();
    checks++;
    if (outs !== e || pc_stall !== 1'b0) begin
      errors++; $display("FAIL branch_vs_lu got %b want %b", outs, e);
    end
    model_step(e);
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (flush_count !== (Perf ? CNT_W'(f0 + 1) : '0)) begin
      errors++; $display("FAIL flush_count got %0d want %0d", flush_count, Perf ? f0 + 1 : 0);
    end
  endtask

  task automatic test_muldiv();
    logic [8:0] e;
    int starts, stalls;
    longint s0;
    starts = 0; stalls = 0; s0 = m_stall;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      set_idle();
      is_muldiv = (c <= 4);
      md_done   = (c == 4);
      #1;
      e = model_outs();
      checks++;
      if (outs !== e) begin
        errors++; $display("FAIL muldiv[%0d] got %b want %b", c, outs, e);
      end
      starts += int'(md_start);
      stalls += int'(pc_stall);
      model_step(e);
    end
    checks++;
    if (starts != 1 || stalls != 4) begin
      errors++; $display("FAIL muldiv_counts got start=%0d stall=%0d want 1/4", starts, stalls);
    end
    checks++;
    if (stall_cycles !== (Perf ? CNT_W'(s0 + 4) : '0)) begin
      errors++; $display("FAIL stall_cycles got %0d want %0d", stall_cycles, Perf ? s0 + 4 : 0);
    end
  endtask

  // done_at: cycle index (0 = md_start) at which md_done pulses, or -1 for never
  task automatic test_watchdog(input string name, input int done_at);
    logic [8:0] e;
    for (int c = 0; c <= T + 2; c++) begin
      @(negedge clk);
      set_idle();
      is_muldiv = (c <= T);
      md_done   = (c == done_at);
      #1;
      e = model_outs();
      checks++;
      if (outs !== e) begin
        errors++; $display("FAIL %s[%0d] got %b want %b", name, c, outs, e);
      end
      if (c == T) begin
        checks++;
        if (md_abort !== (done_at < 0)) begin
          errors++; $display("FAIL %s_abort got %b want %b", name, md_abort, done_at < 0);
        end
      end
      model_step(e);
    end
    checks++;
    if (md_timeout !== (done_at < 0)) begin
      errors++; $display("FAIL %s_sticky got %b want %b", name, md_timeout, done_at < 0);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [8:0] e;
    do_reset(1);
    @(negedge clk); set_idle(); is_muldiv = 1; #1;
    e = model_outs(); model_step(e);
    @(negedge clk); #1;
    e = model_outs(); model_step(e);
    #2;
    set_idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 9'd0) begin
      errors++; $display("FAIL rst_mid_busy got %b want %b", outs, 9'd0);
    end
    do_reset(2);
    @(negedge clk); set_idle(); is_muldiv = 1; #1;
    e = model_outs();
    checks++;
    if (outs !== e || md_start !== 1'b1) begin
      errors++; $display("FAIL fresh_start got %b want %b", outs, e);
    end
    model_step(e);
    @(negedge clk); is_muldiv = 1; md_done = 1; #1;
    e = model_outs();
    model_step(e);
  endtask

  task automatic test_random(input int n);
    logic [8:0] e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      use1 = 1'($urandom); use2 = 1'($urandom); mem_read = 1'($urandom);
      is_muldiv = ($urandom_range(0, 3) == 0) || m_busy;
      md_done   = ($urandom_range(0, 5) == 0);
      branch    = ($urandom_range(0, 4) == 0);
      #1;
      e = model_outs();
      checks++;
      if (outs !== e) begin
        errors++; $display("FAIL random[%0d] got %b want %b", c, outs, e);
      end
      checks++;
      if (stall_cycles !== (Perf ? CNT_W'(m_stall) : '0) ||
          flush_count !== (Perf ? CNT_W'(m_flush) : '0)) begin
        errors++;
        $display("FAIL random_cnt[%0d] got %0d/%0d want %0d/%0d", c, stall_cycles,
                 flush_count, Perf ? m_stall : 0, Perf ? m_flush : 0);
      end
      model_step(e);
    end
  endtask

  initial begin
    set_idle();
    rst_n = 1'b1;
    m_busy = 0; m_elapsed = 0; m_to = 0; m_stall = 0; m_flush = 0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_muldiv();
    test_watchdog("watchdog", -1);
    do_reset(1);
    test_watchdog("done_at_timeout", T);
    test_reset_mid_busy();
    do_reset(1);
    test_random(2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
